// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch FSM states, IF/ID bundle and common constants.
// Imported by every pipeline stage and pipeline register.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, stall holds contents.
// A bubble keeps pc_plus4 so downstream link values stay stable.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.instr <= NOP;
            q.valid <= 1'b0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, BOOT/RUN/HALTED control,
// combinational imem lookup and the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              AW       = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic [AW-1:0]   imem_addr,
    input  logic [XLEN-1:0] imem_rd,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            id_valid,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_e    state;
    logic            run;
    logic            load_bubble;
    logic            hold;
    logic            advance;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    assign run       = (state == RUN);
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[AW+1:2];

    // Halt wins over everything; outside RUN the register simply holds.
    assign load_bubble = run & (halt | flush | redirect_valid);
    assign hold        = ~run | stall;
    assign advance     = run & ~load_bubble & ~stall;

    always_comb begin
        next_pc = pc;
        if (run && !halt) begin
            if (redirect_valid) begin
                next_pc = {redirect_pc[XLEN-1:2], 2'b00};
            end else if (!stall) begin
                next_pc = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            pc <= next_pc;
            if (advance) begin
                fetch_count <= fetch_count + 32'd1;
            end
            unique case (state)
                BOOT:    state <= RUN;
                RUN:     state <= halt ? HALTED : RUN;
                HALTED:  state <= HALTED;
                default: state <= BOOT;
            endcase
        end
    end

    assign if_id_d = '{
        instr:    imem_rd,
        pc_plus4: pc_plus4,
        valid:    1'b1
    };

    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (hold),
        .flush (load_bubble),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign id_instr    = if_id_q.instr;
    assign id_pc_plus4 = if_id_q.pc_plus4;
    assign id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table,
// random traffic against a reference model, reset and halt sequences.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    // Reference model state; mode 0 = boot, 1 = running, 2 = halted
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_cnt;

    typedef struct {
        logic        s;
        logic        f;
        logic        r;
        logic [31:0] rp;
        logic        h;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .AW       (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .pc             (pc),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4),
        .id_valid       (id_valid),
        .fetch_count    (fetch_count)
    );

    assign imem_rd = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".addr"}, {26'h0, imem_addr}, (m_pc / 4) % 64);
        chk({tag, ".instr"}, id_instr, m_instr);
        chk({tag, ".pc4"}, id_pc_plus4, m_pc4);
        chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, m_valid});
        chk({tag, ".cnt"}, fetch_count, m_cnt);
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge
    task automatic step(input logic s, input logic f, input logic r,
                        input logic [31:0] rp, input logic h,
                        input string tag);
        int          n_mode;
        logic [31:0] n_pc;
        logic [31:0] n_instr;
        logic [31:0] n_pc4;
        logic        n_valid;
        logic [31:0] n_cnt;
        stall          = s;
        flush          = f;
        redirect_valid = r;
        redirect_pc    = rp;
        halt           = h;
        n_mode  = m_mode;
        n_pc    = m_pc;
        n_instr = m_instr;
        n_pc4   = m_pc4;
        n_valid = m_valid;
        n_cnt   = m_cnt;
        if (m_mode == 0) begin
            n_mode = 1;
        end else if (m_mode == 1) begin
            if (h) begin
                n_mode  = 2;
                n_instr = 32'h0;
                n_valid = 1'b0;
            end else begin
                if (r)
                    n_pc = rp & 32'hFFFF_FFFC;
                else if (!s)
                    n_pc = m_pc + 32'd4;
                if (f || r) begin
                    n_instr = 32'h0;
                    n_valid = 1'b0;
                end else if (!s) begin
                    n_instr = mem[(m_pc / 4) % 64];
                    n_pc4   = m_pc + 32'd4;
                    n_valid = 1'b1;
                    n_cnt   = m_cnt + 32'd1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_mode  = n_mode;
        m_pc    = n_pc;
        m_instr = n_instr;
        m_pc4   = n_pc4;
        m_valid = n_valid;
        m_cnt   = n_cnt;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        //                s  f  r  rp            h  pc            pc4           v  cnt
        vecs.push_back(vec_t'{0, 0, 1, 32'h80,       0, 32'h0,        32'h0,        0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h4,        32'h4,        1, 1});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h8,        32'h8,        1, 2});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'hC,        32'hC,        1, 3});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h10,       32'h10,       1, 4});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,        0, 32'h10,       32'h10,       1, 4});
        vecs.push_back(vec_t'{1, 0, 0, 32'h0,        0, 32'h10,       32'h10,       1, 4});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h14,       32'h14,       1, 5});
        vecs.push_back(vec_t'{1, 0, 1, 32'h43,       0, 32'h40,       32'h14,       0, 5});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h44,       32'h44,       1, 6});
        vecs.push_back(vec_t'{0, 1, 0, 32'h0,        0, 32'h48,       32'h44,       0, 6});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h4C,       32'h4C,       1, 7});
        vecs.push_back(vec_t'{0, 0, 1, 32'hFC,       0, 32'hFC,       32'h4C,       0, 7});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h100,      32'h100,      1, 8});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h104,      32'h104,      1, 9});
        vecs.push_back(vec_t'{0, 0, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFC, 32'h104,      0, 9});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 10});
        vecs.push_back(vec_t'{0, 0, 0, 32'h0,        0, 32'h4,        32'h4,        1, 11});

        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        rst_n          = 1'b0;
        model_reset();
        #12;
        check_all("reset");

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("boot");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].s, vecs[i].f, vecs[i].r, vecs[i].rp, vecs[i].h,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tpc", i), pc, vecs[i].e_pc);
            chk($sformatf("vec%0d.tpc4", i), id_pc_plus4, vecs[i].e_pc4);
            chk($sformatf("vec%0d.tv", i), {31'h0, id_valid},
                {31'h0, vecs[i].e_valid});
            chk($sformatf("vec%0d.tcnt", i), fetch_count, vecs[i].e_cnt);
            if (i == 9) chk("redir_instr", id_instr, mem[16]);
            if (i == 13) chk("wrap_addr", {26'h0, imem_addr}, 32'h0);
            if (i == 14) chk("alias_instr", id_instr, mem[0]);
        end

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom, 1'b0, "rand");
        end

        // Asynchronous reset between edges with a redirect and stall pending
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        stall          = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        check_all("in_rst");
        stall          = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        check_all("rel_boot");
        step(0, 0, 0, 32'h0, 0, "rel_run");
        step(0, 0, 0, 32'h0, 0, "rel_pc4");
        chk("rel_pc", pc, 32'h4);

        step(0, 0, 1, 32'h20, 0, "to20");
        step(0, 0, 0, 32'h0, 1, "halt");
        chk("halt_pc", pc, 32'h20);
        for (int i = 0; i < 20; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                 "halted");
            chk("halted_pc", pc, 32'h20);
            chk("halted_v", {31'h0, id_valid}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
